// File: rtl/pipe_ctrl.sv
// Pause/flush sequencer for the 5-stage pipeline: hazard priority, branch/trap redirect, drain.
// Optional PIPE_CTRL_PERF_EN adds saturating stall/redirect counters.
module pipe_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned STAGES       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_use,
  input  logic              ex_busy,
  input  logic              mem_busy,
  input  logic              br_taken,
  input  logic [XLEN-1:0]   br_target,
  input  logic              trap_req,
  input  logic [XLEN-1:0]   trap_vec,
  output logic [STAGES-1:0] pause,
  output logic [STAGES-1:0] flush,
  output logic              redirect,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       redir_cnt,
`endif
  output logic [XLEN-1:0]   target
);

  localparam int unsigned CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  // Bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB.
  localparam logic [STAGES-1:0] FlTrap  = 5'b01111;
  localparam logic [STAGES-1:0] PsMem   = 5'b01111;
  localparam logic [STAGES-1:0] FlMem   = 5'b10000;
  localparam logic [STAGES-1:0] PsEx    = 5'b00111;
  localparam logic [STAGES-1:0] FlEx    = 5'b01000;
  localparam logic [STAGES-1:0] FlBr    = 5'b00110;
  localparam logic [STAGES-1:0] PsLd    = 5'b00011;
  localparam logic [STAGES-1:0] FlLd    = 5'b00100;
  localparam logic [STAGES-1:0] PsDrain = 5'b00001;

  typedef enum logic [1:0] {StRun, StStall, StDrain} state_e;

  state_e          state_q, state_d;
  logic            br_pend_q, br_pend_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      br_pend_q  <= 1'b0;
      pend_tgt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      br_pend_q  <= br_pend_d;
      pend_tgt_q <= pend_tgt_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    br_pend_d  = br_pend_q;
    pend_tgt_d = pend_tgt_q;
    cnt_d      = cnt_q;
    pause      = '0;
    flush      = '0;
    redirect   = 1'b0;
    target     = '0;

    if (trap_req) begin
      // Trap wins in every state, including a restart from DRAIN.
      flush     = FlTrap;
      redirect  = 1'b1;
      target    = trap_vec;
      br_pend_d = 1'b0;
      if (DRAIN_CYCLES > 0) begin
        state_d = StDrain;
        cnt_d   = CntW'(DRAIN_CYCLES);
      end else begin
        state_d = StRun;
      end
    end else if (state_q == StDrain) begin
      pause = PsDrain;
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) state_d = StRun;
    end else if (mem_busy || ex_busy) begin
      pause   = mem_busy ? PsMem : PsEx;
      flush   = mem_busy ? FlMem : FlEx;
      state_d = StStall;
      // Youngest branch resolved during the stall is the one replayed.
      if (br_taken) begin
        br_pend_d  = 1'b1;
        pend_tgt_d = br_target;
      end
    end else if (br_taken || br_pend_q) begin
      redirect  = 1'b1;
      flush     = FlBr;
      target    = br_taken ? br_target : pend_tgt_q;
      br_pend_d = 1'b0;
      state_d   = StRun;
    end else if (ld_use) begin
      pause   = PsLd;
      flush   = FlLd;
      state_d = StRun;
    end else begin
      state_d = StRun;
    end

    if (!rst) begin
      pause    = '0;
      flush    = '1;
      redirect = 1'b0;
      target   = '0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      if (|pause && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (redirect && redir_cnt != '1) redir_cnt <= redir_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expected outputs from a priority model, checked
// by an independent monitor on the falling edge.
module tb_pipe_ctrl;

  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_use = 1'b0, ex_busy = 1'b0, mem_busy = 1'b0, br_taken = 1'b0, trap_req = 1'b0;
  logic [31:0] br_target = '0, trap_vec = '0, target;
  logic [4:0]  pause, flush;
  logic        redirect;
  logic [31:0] stall_cnt, redir_cnt;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ld_use    (ld_use),
    .ex_busy   (ex_busy),
    .mem_busy  (mem_busy),
    .br_taken  (br_taken),
    .br_target (br_target),
    .trap_req  (trap_req),
    .trap_vec  (trap_vec),
    .pause     (pause),
    .flush     (flush),
    .redirect  (redirect),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cnt (stall_cnt),
    .redir_cnt (redir_cnt),
`endif
    .target    (target)
  );

`ifndef PIPE_CTRL_PERF_EN
  assign stall_cnt = '0;
  assign redir_cnt = '0;
`endif

  typedef struct packed {
    logic [4:0]  pause;
    logic [4:0]  flush;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] sc;
    logic [31:0] rc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Reference state: pending branch, remaining drain cycles, perf counts.
  bit          m_pend = 0;
  logic [31:0] m_ptgt = '0;
  int          m_drain = 0;
  logic [31:0] m_sc = '0, m_rc = '0;

  task automatic step(input bit r, input bit l, input bit e, input bit m, input bit b,
                      input logic [31:0] bt, input bit t, input logic [31:0] tv);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; ld_use = l; ex_busy = e; mem_busy = m; br_taken = b; br_target = bt;
    trap_req = t; trap_vec = tv;
    x = '0;
    if (!r) begin
      x.flush = 5'h1F;
      m_pend = 0; m_ptgt = '0; m_drain = 0; m_sc = '0; m_rc = '0;
    end else begin
      if (t) begin
        x.flush = 5'b01111; x.redirect = 1; x.target = tv;
        m_pend = 0; m_drain = DRAIN;
      end else if (m_drain > 0) begin
        x.pause = 5'b00001;
        m_drain--;
      end else if (m || e) begin
        x.pause = m ? 5'b01111 : 5'b00111;
        x.flush = m ? 5'b10000 : 5'b01000;
        if (b) begin m_pend = 1; m_ptgt = bt; end
      end else if (b || m_pend) begin
        x.redirect = 1; x.flush = 5'b00110; x.target = b ? bt : m_ptgt;
        m_pend = 0;
      end else if (l) begin
        x.pause = 5'b00011; x.flush = 5'b00100;
      end
`ifdef PIPE_CTRL_PERF_EN
      x.sc = m_sc; x.rc = m_rc;
      if (x.pause != 0 && m_sc != '1) m_sc++;
      if (x.redirect && m_rc != '1) m_rc++;
`endif
    end
    q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, '0, 0, '0);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        x = q.pop_front();
        total++;
        if (pause !== x.pause || flush !== x.flush || redirect !== x.redirect ||
            target !== x.target || stall_cnt !== x.sc || redir_cnt !== x.rc) begin
          bad++;
          $display("FAIL outputs cyc=%0d got p=%b f=%b r=%b t=%h sc=%0d rc=%0d want p=%b f=%b r=%b t=%h sc=%0d rc=%0d",
                   cyc, pause, flush, redirect, target, stall_cnt, redir_cnt,
                   x.pause, x.flush, x.redirect, x.target, x.sc, x.rc);
        end
      end
    end
  end

  initial begin
    step(0, 0, 0, 0, 0, '0, 0, '0);
    step(0, 0, 0, 0, 0, '0, 0, '0);
    idle(3);
    // Load-use bubble for one cycle.
    step(1, 1, 0, 0, 0, '0, 0, '0);
    idle(1);
    // Branch held across a memory stall.
    step(1, 0, 0, 1, 1, 32'h80, 0, '0);
    step(1, 0, 0, 1, 0, '0, 0, '0);
    step(1, 0, 0, 1, 0, '0, 0, '0);
    idle(2);
    // Trap beats mem_busy, then drain.
    step(1, 0, 0, 1, 0, '0, 1, 32'h100);
    idle(3);
    // Divider stall then a fresh branch.
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, '0, 0, '0);
    step(1, 0, 0, 0, 1, 32'h40, 0, '0);
    idle(1);
    // Trap restart inside drain.
    step(1, 0, 0, 0, 0, '0, 1, 32'h200);
    step(1, 0, 0, 0, 0, '0, 1, 32'h300);
    idle(3);
    // Reset during drain, and during a stall with a pending branch.
    step(1, 0, 0, 0, 0, '0, 1, 32'h100);
    step(0, 0, 0, 0, 0, '0, 0, '0);
    idle(3);
    step(1, 0, 0, 1, 1, 32'h80, 0, '0);
    step(0, 0, 0, 0, 0, '0, 0, '0);
    idle(3);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63) != 0), ($urandom_range(3) == 0), ($urandom_range(5) == 0),
           ($urandom_range(5) == 0), ($urandom_range(3) == 0), $urandom,
           ($urandom_range(15) == 0), $urandom);
    end
    idle(2);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue left=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
